// File: rtl/mem_line_responder_if.sv
// Cache-facing request/response bundle for the line responder.
// I-cache refill port plus D-cache refill/writeback port.
interface mem_line_responder_if #(
   parameter int PHY_LEN  = 20,
   parameter int LINE_LEN = 128
);
   logic                ic_req_valid;
   logic                ic_req_ready;
   logic [PHY_LEN-1:0]  ic_req_addr;
   logic                ic_rsp_valid;
   logic [LINE_LEN-1:0] ic_rsp_data;
   logic                dc_req_valid;
   logic                dc_req_ready;
   logic                dc_req_we;
   logic [PHY_LEN-1:0]  dc_req_addr;
   logic [LINE_LEN-1:0] dc_req_wdata;
   logic                dc_rsp_valid;
   logic [LINE_LEN-1:0] dc_rsp_data;

   modport master (
      output ic_req_valid, ic_req_addr,
      input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
      output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
      input  dc_req_ready, dc_rsp_valid, dc_rsp_data
   );

   modport slave (
      input  ic_req_valid, ic_req_addr,
      output ic_req_ready, ic_rsp_valid, ic_rsp_data,
      input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
      output dc_req_ready, dc_rsp_valid, dc_rsp_data
   );
endinterface

// File: rtl/mem_line_responder.sv
// Line-organised backing store serving I/D cache refills and writebacks.
// One transaction at a time, round-robin grant, fixed response latency.
module mem_line_responder #(
   parameter int PHY_LEN   = 20,
   parameter int LINE_LEN  = 128,
   parameter int MEM_LINES = 256,
   parameter int MEM_LAT   = 5
) (
   input logic                   clk,
   input logic                   rst,
   mem_line_responder_if.slave   io_mem
);
   localparam int IW = $clog2(MEM_LINES);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef enum logic {P_IC, P_DC} port_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nx;
   port_t               r_last;
   port_t               r_port;
   logic                r_we;
   logic [IW-1:0]       r_idx;
   logic [LINE_LEN-1:0] r_wdata;
   logic [LINE_LEN-1:0] r_mem [MEM_LINES];

   logic                r_ic_rsp_valid;
   logic                r_dc_rsp_valid;
   logic [LINE_LEN-1:0] r_ic_rsp_data;
   logic [LINE_LEN-1:0] r_dc_rsp_data;

   logic                w_idle;
   logic                w_ic_rdy;
   logic                w_dc_rdy;
   logic                w_hs;
   port_t               w_in_port;
   logic                w_in_we;
   logic [IW-1:0]       w_in_idx;
   port_t               w_eff_port;
   logic                w_eff_we;
   logic [IW-1:0]       w_eff_idx;
   logic [LINE_LEN-1:0] w_eff_wdata;
   logic                w_resp_nx;
   logic                w_unused_addr;

   // Offset bits and aliasing upper bits do not select a line.
   assign w_unused_addr = ^{io_mem.ic_req_addr[3:0],
                            io_mem.ic_req_addr[PHY_LEN-1:4+IW],
                            io_mem.dc_req_addr[3:0],
                            io_mem.dc_req_addr[PHY_LEN-1:4+IW]};

   assign w_idle   = (r_state == S_IDLE) & ~rst;
   assign w_ic_rdy = w_idle & io_mem.ic_req_valid
                   & (~io_mem.dc_req_valid | (r_last == P_DC));
   assign w_dc_rdy = w_idle & io_mem.dc_req_valid
                   & (~io_mem.ic_req_valid | (r_last == P_IC));
   assign w_hs     = w_ic_rdy | w_dc_rdy;

   assign w_in_port = w_dc_rdy ? P_DC : P_IC;
   assign w_in_we   = w_dc_rdy & io_mem.dc_req_we;
   assign w_in_idx  = w_dc_rdy ? io_mem.dc_req_addr[4 +: IW]
                               : io_mem.ic_req_addr[4 +: IW];

   // With a one-cycle latency the response is set up at the handshake
   // edge itself, before the latched copies exist.
   assign w_eff_port  = (r_state == S_IDLE) ? w_in_port : r_port;
   assign w_eff_we    = (r_state == S_IDLE) ? w_in_we   : r_we;
   assign w_eff_idx   = (r_state == S_IDLE) ? w_in_idx  : r_idx;
   assign w_eff_wdata = (r_state == S_IDLE) ? io_mem.dc_req_wdata
                                            : r_wdata;

   assign w_resp_nx = (w_state_nx == S_RESP);

   assign io_mem.ic_req_ready = w_ic_rdy;
   assign io_mem.dc_req_ready = w_dc_rdy;
   assign io_mem.ic_rsp_valid = r_ic_rsp_valid;
   assign io_mem.dc_rsp_valid = r_dc_rsp_valid;
   assign io_mem.ic_rsp_data  = r_ic_rsp_data;
   assign io_mem.dc_rsp_data  = r_dc_rsp_data;

   // Next-state and latency counter.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_cnt_nx   = CW'(MEM_LAT - 1);
               w_state_nx = (MEM_LAT == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_nx = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
               w_state_nx = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State, counter, grant history and latched request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_last  <= P_IC;
         r_port  <= P_IC;
         r_we    <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         if (w_hs) begin
            r_last  <= w_in_port;
            r_port  <= w_in_port;
            r_we    <= w_in_we;
            r_idx   <= w_in_idx;
            r_wdata <= io_mem.dc_req_wdata;
         end
      end
   end

   // Response pulse and data, registered on entry to RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ic_rsp_valid <= 1'b0;
         r_dc_rsp_valid <= 1'b0;
         r_ic_rsp_data  <= '0;
         r_dc_rsp_data  <= '0;
      end else begin
         r_ic_rsp_valid <= w_resp_nx & (w_eff_port == P_IC);
         r_dc_rsp_valid <= w_resp_nx & (w_eff_port == P_DC);
         if (w_resp_nx && (w_eff_port == P_IC)) begin
            r_ic_rsp_data <= r_mem[w_eff_idx];
         end
         if (w_resp_nx && (w_eff_port == P_DC)) begin
            r_dc_rsp_data <= w_eff_we ? w_eff_wdata : r_mem[w_eff_idx];
         end
      end
   end

   // Backing store; survives reset, commits a write with its response.
   always_ff @(posedge clk) begin
      if (!rst && w_resp_nx && w_eff_we) begin
         r_mem[w_eff_idx] <= w_eff_wdata;
      end
   end
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency-5 and latency-1
// instances, arbitration, aliasing and reset mid-transaction.
module tb_mem_line_responder;
   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] D2 = 128'hDEADBEEFCAFEF00D1122334455667788;
   localparam logic [127:0] D3 = 128'hA5A5A5A5000011112222333344445555;
   localparam logic [127:0] D4 = 128'h5A5A5A5A999988887777666655554444;
   localparam logic [127:0] D5 = 128'hFEEDFACE0BADC0DE1357924680ACE000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_dc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (ma.dc_rsp_valid) n_dc++;
   end

   mem_line_responder_if #(.PHY_LEN(20), .LINE_LEN(128)) ma ();
   mem_line_responder_if #(.PHY_LEN(20), .LINE_LEN(128)) mb ();

   mem_line_responder #(
      .PHY_LEN(20), .LINE_LEN(128), .MEM_LINES(256), .MEM_LAT(5)
   ) u_a (.clk(clk), .rst(rst), .io_mem(ma));

   mem_line_responder #(
      .PHY_LEN(20), .LINE_LEN(128), .MEM_LINES(256), .MEM_LAT(1)
   ) u_b (.clk(clk), .rst(rst), .io_mem(mb));

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dc_go(input logic we, input logic [19:0] a,
                        input logic [127:0] d, output int t);
      ma.dc_req_valid = 1'b1;
      ma.dc_req_we    = we;
      ma.dc_req_addr  = a;
      ma.dc_req_wdata = d;
      t = -1;
      for (int i = 0; i < 30 && t < 0; i++) begin
         @(negedge clk);
         if (ma.dc_req_ready) t = cyc;
         step();
      end
      ma.dc_req_valid = 1'b0;
      if (t < 0) chk("dc_hs_timeout", 0, 1);
   endtask

   task automatic ic_go(input logic [19:0] a, output int t);
      ma.ic_req_valid = 1'b1;
      ma.ic_req_addr  = a;
      t = -1;
      for (int i = 0; i < 30 && t < 0; i++) begin
         @(negedge clk);
         if (ma.ic_req_ready) t = cyc;
         step();
      end
      ma.ic_req_valid = 1'b0;
      if (t < 0) chk("ic_hs_timeout", 0, 1);
   endtask

   task automatic rsp_wait(input bit dc, output int t,
                           output logic [127:0] d);
      t = -1;
      d = '0;
      for (int i = 0; i < 30 && t < 0; i++) begin
         @(negedge clk);
         if (dc ? ma.dc_rsp_valid : ma.ic_rsp_valid) begin
            t = cyc;
            d = dc ? ma.dc_rsp_data : ma.ic_rsp_data;
         end
      end
      step();
      if (t < 0) chk("rsp_timeout", 0, 1);
   endtask

   task automatic xact(input bit dc, input logic we, input logic [19:0] a,
                       input logic [127:0] wd, output logic [127:0] rd,
                       output int lat);
      int th;
      int tr;
      if (dc) dc_go(we, a, wd, th);
      else    ic_go(a, th);
      rsp_wait(dc, tr, rd);
      lat = tr - th;
   endtask

   initial begin
      logic [127:0] rd;
      int lat, k, both, s, t1, t2, th, th2, tr, nd;
      int g[4];
      int tg[4];
      int bh[2];
      int br;
      logic [127:0] bd;

      ma.ic_req_valid = 0; ma.ic_req_addr = '0;
      ma.dc_req_valid = 0; ma.dc_req_we = 0;
      ma.dc_req_addr = '0; ma.dc_req_wdata = '0;
      mb.ic_req_valid = 0; mb.ic_req_addr = '0;
      mb.dc_req_valid = 0; mb.dc_req_we = 0;
      mb.dc_req_addr = '0; mb.dc_req_wdata = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_ic_valid", ma.ic_rsp_valid, 0);
      chk("rst_dc_valid", ma.dc_rsp_valid, 0);
      chk("rst_ic_data", ma.ic_rsp_data, 0);
      chk("rst_dc_data", ma.dc_rsp_data, 0);
      chk("rst_ic_ready_novalid", ma.ic_req_ready, 0);
      step();

      // Round-robin with both requesters always valid
      ma.ic_req_valid = 1; ma.ic_req_addr = 20'h00000;
      ma.dc_req_valid = 1; ma.dc_req_we = 0; ma.dc_req_addr = 20'h00010;
      k = 0; both = 0;
      for (int i = 0; i < 60 && k < 4; i++) begin
         @(negedge clk);
         if (ma.ic_req_ready && ma.dc_req_ready) both++;
         if (ma.dc_req_ready) begin
            g[k] = 1; tg[k] = cyc; k++;
         end else if (ma.ic_req_ready) begin
            g[k] = 0; tg[k] = cyc; k++;
         end
         step();
      end
      ma.ic_req_valid = 0; ma.dc_req_valid = 0;
      chk("rr_grants", k, 4);
      chk("rr_g0_dc", g[0], 1);
      chk("rr_g1_ic", g[1], 0);
      chk("rr_g2_dc", g[2], 1);
      chk("rr_g3_ic", g[3], 0);
      chk("rr_gap01", tg[1] - tg[0], 6);
      chk("rr_gap12", tg[2] - tg[1], 6);
      chk("rr_gap23", tg[3] - tg[2], 6);
      chk("rr_both_ready", both, 0);
      repeat (8) step();

      // Write then read back
      xact(1, 1, 20'h00040, D1, rd, lat);
      chk("wr_echo", rd, D1);
      chk("wr_lat", lat, 5);
      xact(0, 0, 20'h00040, '0, rd, lat);
      chk("rd_data", rd, D1);
      chk("rd_lat", lat, 5);

      // Lone IC requester after an IC grant
      ma.ic_req_valid = 1; ma.ic_req_addr = 20'h00040;
      s = cyc; t1 = -1; t2 = -1;
      for (int i = 0; i < 30 && t2 < 0; i++) begin
         @(negedge clk);
         if (ma.ic_req_ready) begin
            if (t1 < 0) t1 = cyc;
            else        t2 = cyc;
         end
         step();
      end
      ma.ic_req_valid = 0;
      chk("single_first", t1, s);
      chk("single_gap", t2 - t1, 6);
      repeat (8) step();

      // Offset and aliasing
      xact(1, 1, 20'h0004F, D2, rd, lat);
      chk("alias_wr_echo", rd, D2);
      xact(0, 0, 20'h00040, '0, rd, lat);
      chk("alias_rd_40", rd, D2);
      xact(1, 0, 20'h01040, '0, rd, lat);
      chk("alias_rd_1040", rd, D2);

      // Reset during WAIT drops a write
      xact(1, 1, 20'h00080, D3, rd, lat);
      chk("pre_wr_echo", rd, D3);
      dc_go(1, 20'h00080, D4, th);
      step();
      rst = 1; ma.ic_req_valid = 1; ma.ic_req_addr = 20'h00080;
      nd = n_dc;
      @(negedge clk);
      chk("rdy_in_rst", ma.ic_req_ready, 0);
      step();
      rst = 0;
      @(negedge clk);
      chk("rdy_after_rst", ma.ic_req_ready, 1);
      chk("dc_data_cleared", ma.dc_rsp_data, 0);
      th2 = cyc;
      step();
      ma.ic_req_valid = 0;
      rsp_wait(0, tr, rd);
      chk("post_rst_rd", rd, D3);
      chk("post_rst_lat", tr - th2, 5);
      repeat (5) step();
      chk("no_dc_rsp_dropped", n_dc - nd, 0);

      // Latency-1 instance
      mb.dc_req_valid = 1; mb.dc_req_we = 1;
      mb.dc_req_addr = 20'h00100; mb.dc_req_wdata = D5;
      th = -1;
      for (int i = 0; i < 10 && th < 0; i++) begin
         @(negedge clk);
         if (mb.dc_req_ready) th = cyc;
         step();
      end
      mb.dc_req_valid = 0;
      @(negedge clk);
      chk("l1_wr_hs_next", cyc - th, 1);
      chk("l1_wr_valid", mb.dc_rsp_valid, 1);
      chk("l1_wr_echo", mb.dc_rsp_data, D5);
      step();
      mb.ic_req_valid = 1; mb.ic_req_addr = 20'h00100;
      k = 0; br = -1; bd = '0; bh[0] = -1; bh[1] = -1;
      for (int i = 0; i < 20 && k < 2; i++) begin
         @(negedge clk);
         if (mb.ic_rsp_valid && br < 0) begin
            br = cyc; bd = mb.ic_rsp_data;
         end
         if (mb.ic_req_ready) begin
            bh[k] = cyc; k++;
         end
         step();
      end
      mb.ic_req_valid = 0;
      chk("l1_rd_lat", br - bh[0], 1);
      chk("l1_rd_data", bd, D5);
      chk("l1_next_hs", bh[1] - bh[0], 2);
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
